// File: rtl/sparse_chunk_writer.sv
// sparse_chunk_writer: producer side of a ping-pong sparse write port.
// Each accepted dense beat is compressed into a sparsemap plus left-packed
// nonzero bytes and written one cycle later into the bank being filled.
// A bank stays full after its last beat until the consumer releases it.
// Optional feature macro: NNZ_COUNT_EN adds chunk_nnz_o, the nonzero byte
// total of each chunk, presented alongside chunk_done_o.
module sparse_chunk_writer #(
    parameter int BUS_SIZE = 8,
    parameter int MEM_SIZE = 32
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [BUS_SIZE*8-1:0]                         dense_dat_i,
    input  logic                                          dense_val_i,
    output logic                                          dense_rdy_o,
    input  logic                                          buf_release_i,
    input  logic                                          buf_release_sel_i,
    output logic [BUS_SIZE-1:0]                           sparsemap_o,
    output logic [BUS_SIZE*8-1:0]                         nonzero_data_o,
    output logic                                          wr_valid_o,
    output logic [$clog2(MEM_SIZE/BUS_SIZE)-1:0]          wr_count_o,
    output logic                                          wr_sel_o,
    output logic                                          chunk_done_o,
`ifdef NNZ_COUNT_EN
    output logic [$clog2(MEM_SIZE):0]                     chunk_nnz_o,
`endif
    output logic [1:0]                                    buf_full_o
);

    localparam int WR_DAT_CYC_NUM = MEM_SIZE / BUS_SIZE;
    localparam int CNT_W          = $clog2(WR_DAT_CYC_NUM);
    localparam int PC_W           = $clog2(BUS_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WR_DAT_CYC_NUM - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } fill_state_t;

    fill_state_t      state, state_nxt;
    logic             fill_sel, fill_sel_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [1:0]       buf_full, buf_full_nxt;
    logic             accept;
    logic             last_beat;

    // Bit i flags a nonzero byte i of the beat.
    function automatic logic [BUS_SIZE-1:0] sparse_map(input logic [BUS_SIZE*8-1:0] dat);
        logic [BUS_SIZE-1:0] m;
        m = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            m[i] = |dat[8*i +: 8];
        end
        return m;
    endfunction

    // Nonzero bytes moved to the lowest slots in ascending index order;
    // unused upper slots stay zero.
    function automatic logic [BUS_SIZE*8-1:0] pack_nonzero(input logic [BUS_SIZE*8-1:0] dat);
        logic [BUS_SIZE*8-1:0] p;
        int                    k;
        p = '0;
        k = 0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            if (|dat[8*i +: 8]) begin
                p[8*k +: 8] = dat[8*i +: 8];
                k++;
            end
        end
        return p;
    endfunction

    // Number of set bits in a sparsemap.
    function automatic logic [PC_W-1:0] popcount(input logic [BUS_SIZE-1:0] m);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            c = c + PC_W'(m[i]);
        end
        return c;
    endfunction

    // Ready depends only on registered state and the reset input, never on valid.
    assign dense_rdy_o = rst_i & (state == ST_FILL) & ~buf_full[fill_sel];
    assign accept      = dense_val_i & dense_rdy_o;
    assign last_beat   = accept & (beat_cnt == LAST_BEAT);
    assign buf_full_o  = buf_full;

    // Next-state logic for bank flags, beat counter and fill pointer.
    always_comb begin
        state_nxt    = state;
        fill_sel_nxt = fill_sel;
        beat_cnt_nxt = beat_cnt;
        buf_full_nxt = buf_full;

        // Clearing an already-empty bank is a harmless no-op; the set below
        // targets the bank being filled, which cannot be full, so it wins.
        if (buf_release_i) begin
            buf_full_nxt[buf_release_sel_i] = 1'b0;
        end

        if (accept) begin
            if (last_beat) begin
                beat_cnt_nxt           = '0;
                buf_full_nxt[fill_sel] = 1'b1;
                fill_sel_nxt           = ~fill_sel;
            end else begin
                beat_cnt_nxt = beat_cnt + 1'b1;
            end
        end

        case (state)
            ST_FILL: begin
                if (last_beat && buf_full_nxt[~fill_sel]) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!buf_full_nxt[fill_sel]) begin
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    // Control state register; a reset mid-chunk drops the partial chunk.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= ST_FILL;
            fill_sel <= 1'b0;
            beat_cnt <= '0;
            buf_full <= 2'b00;
        end else begin
            state    <= state_nxt;
            fill_sel <= fill_sel_nxt;
            beat_cnt <= beat_cnt_nxt;
            buf_full <= buf_full_nxt;
        end
    end

    // Write strobe and chunk-done pulse: one cycle after each accept.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_valid_o   <= 1'b0;
            chunk_done_o <= 1'b0;
        end else begin
            wr_valid_o   <= accept;
            chunk_done_o <= last_beat;
        end
    end

    // Write payload: captured on accept, held between writes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sparsemap_o    <= '0;
            nonzero_data_o <= '0;
            wr_count_o     <= '0;
            wr_sel_o       <= 1'b0;
        end else if (accept) begin
            sparsemap_o    <= sparse_map(dense_dat_i);
            nonzero_data_o <= pack_nonzero(dense_dat_i);
            wr_count_o     <= beat_cnt;
            wr_sel_o       <= fill_sel;
        end
    end

`ifdef NNZ_COUNT_EN
    localparam int NNZ_W = $clog2(MEM_SIZE) + 1;

    logic [NNZ_W-1:0] nnz_acc;
    logic [NNZ_W-1:0] nnz_sum;

    assign nnz_sum = nnz_acc + NNZ_W'(popcount(sparse_map(dense_dat_i)));

    // Per-chunk nonzero total; published with the last beat, then restarted.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            nnz_acc     <= '0;
            chunk_nnz_o <= '0;
        end else if (accept) begin
            if (last_beat) begin
                nnz_acc     <= '0;
                chunk_nnz_o <= nnz_sum;
            end else begin
                nnz_acc <= nnz_sum;
            end
        end
    end
`else
    // Popcount is only needed by the optional nonzero counter.
    logic [PC_W-1:0] unused_pc;
    assign unused_pc = popcount('0);
`endif

endmodule

// File: tb/tb_sparse_chunk_writer.sv
// Self-checking bench for sparse_chunk_writer (BUS_SIZE=8, MEM_SIZE=32).
// A queue-based reference model tracks bank occupancy, fill bank and beat
// index, and predicts every output each cycle.
module tb_sparse_chunk_writer;

    logic        clk;
    logic        rst_n;
    logic [63:0] dense_dat;
    logic        dense_val;
    logic        dense_rdy;
    logic        buf_release;
    logic        buf_release_sel;
    logic [7:0]  sparsemap;
    logic [63:0] nonzero_data;
    logic        wr_valid;
    logic [1:0]  wr_count;
    logic        wr_sel;
    logic        chunk_done;
    logic [1:0]  buf_full;
`ifdef NNZ_COUNT_EN
    logic [5:0]  chunk_nnz;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_full [2];
    int          m_fill;
    int          m_cnt;
    int          m_acc;
    int          m_nnz;
    logic        m_valid, m_done, m_sel;
    logic [1:0]  m_count;
    logic [7:0]  m_map;
    logic [63:0] m_data;

    sparse_chunk_writer #(.BUS_SIZE(8), .MEM_SIZE(32)) dut (
        .clk_i             (clk),
        .rst_i             (rst_n),
        .dense_dat_i       (dense_dat),
        .dense_val_i       (dense_val),
        .dense_rdy_o       (dense_rdy),
        .buf_release_i     (buf_release),
        .buf_release_sel_i (buf_release_sel),
        .sparsemap_o       (sparsemap),
        .nonzero_data_o    (nonzero_data),
        .wr_valid_o        (wr_valid),
        .wr_count_o        (wr_count),
        .wr_sel_o          (wr_sel),
        .chunk_done_o      (chunk_done),
`ifdef NNZ_COUNT_EN
        .chunk_nnz_o       (chunk_nnz),
`endif
        .buf_full_o        (buf_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model update for one clock edge with the given inputs.
    task automatic model_edge(input logic val, input logic [63:0] dat, input logic rel,
                              input logic relsel, input logic rst);
        logic [7:0] q[$];
        logic       acc;
        if (!rst) begin
            m_full[0] = 0; m_full[1] = 0;
            m_fill = 0; m_cnt = 0; m_acc = 0; m_nnz = 0;
            m_valid = 0; m_done = 0; m_sel = 0; m_count = 0;
            m_map = 0; m_data = 0;
            return;
        end
        acc     = val && !m_full[m_fill];
        m_valid = acc;
        m_done  = 0;
        if (acc) begin
            for (int i = 0; i < 8; i++) begin
                if (dat[8*i +: 8] != 8'd0) q.push_back(dat[8*i +: 8]);
            end
            m_map  = 0;
            m_data = 0;
            for (int i = 0; i < 8; i++) m_map[i] = (dat[8*i +: 8] != 8'd0);
            foreach (q[k]) m_data[8*k +: 8] = q[k];
            m_count = 2'(m_cnt);
            m_sel   = m_fill[0];
            m_acc   = m_acc + q.size();
        end
        if (rel) m_full[relsel] = 0;
        if (acc) begin
            if (m_cnt == 3) begin
                m_full[m_fill] = 1;
                m_fill = 1 - m_fill;
                m_cnt  = 0;
                m_done = 1;
                m_nnz  = m_acc;
                m_acc  = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // One clock cycle: apply inputs, check ready, clock, check outputs.
    task automatic cycle(input logic val, input logic [63:0] dat, input logic rel,
                         input logic relsel, input logic rst);
        dense_val = val; dense_dat = dat; buf_release = rel;
        buf_release_sel = relsel; rst_n = rst;
        #1;
        check("dense_rdy", {63'd0, dense_rdy}, {63'd0, rst & !m_full[m_fill]});
        model_edge(val, dat, rel, relsel, rst);
        @(posedge clk);
        #1;
        check("wr_valid",   {63'd0, wr_valid},   {63'd0, m_valid});
        check("chunk_done", {63'd0, chunk_done}, {63'd0, m_done});
        check("buf_full",   {62'd0, buf_full},   {62'd0, m_full[1], m_full[0]});
        check("sparsemap",  {56'd0, sparsemap},  {56'd0, m_map});
        check("nz_data",    nonzero_data,        m_data);
        check("wr_count",   {62'd0, wr_count},   {62'd0, m_count});
        check("wr_sel",     {63'd0, wr_sel},     {63'd0, m_sel});
`ifdef NNZ_COUNT_EN
        check("chunk_nnz",  {58'd0, chunk_nnz},  64'(m_nnz));
`endif
    endtask

    task automatic idle();
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [63:0] rand_beat();
        logic [63:0] d;
        for (int i = 0; i < 8; i++) begin
            d[8*i +: 8] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        end
        return d;
    endfunction

    initial begin
        dense_val = 0; dense_dat = 0; buf_release = 0; buf_release_sel = 0; rst_n = 0;
        model_edge(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset state
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        check("rst_buf_full", {62'd0, buf_full}, 64'd0);

        // Single beat {0,5,0,0,7,0,0,9}
        cycle(1'b1, 64'h0900_0007_0000_0500, 1'b0, 1'b0, 1'b1);
        check("t1_map",  {56'd0, sparsemap}, 64'h92);
        check("t1_data", nonzero_data, 64'h0000_0000_0009_0705);

        // All-zero beat then a fully dense beat
        cycle(1'b1, 64'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 64'h0807_0605_0403_0201, 1'b0, 1'b0, 1'b1);
        check("t2_map",  {56'd0, sparsemap}, 64'hFF);
        check("t2_data", nonzero_data, 64'h0807_0605_0403_0201);

        // Restart clean, then 8 back-to-back beats with no release
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, rand_beat(), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_beat(), 1'b0, 1'b0, 1'b1);
        check("t3_full", {62'd0, buf_full}, 64'd3);
        cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        idle();
        cycle(1'b1, 64'h0000_0000_0000_00AA, 1'b0, 1'b0, 1'b1);
        check("t3_sel",   {63'd0, wr_sel},   64'd0);
        check("t3_count", {62'd0, wr_count}, 64'd0);

        // Toggling valid, release of an empty bank while filling
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(i[0] == 1'b0, rand_beat(), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);

        // Reset mid-chunk discards the partial chunk
        cycle(1'b1, rand_beat(), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, rand_beat(), 1'b0, 1'b0, 1'b1);
        check("t5_count", {62'd0, wr_count}, 64'd0);

`ifdef NNZ_COUNT_EN
        // Four beats with three nonzero bytes each
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'h0000_1100_2200_0033, 1'b0, 1'b0, 1'b1);
        check("t6_nnz", {58'd0, chunk_nnz}, 64'd12);
`endif

        // Randomized traffic with releases and occasional resets
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0, rand_beat(),
                  $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 149) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
